// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic-array fetch path.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEF_MATRIX_SIZE = 2;
    localparam int DEF_DATA_SIZE   = 32;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef logic [DEF_MATRIX_SIZE-1:0][DEF_DATA_SIZE-1:0] row_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int drain_w(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO of row vectors, each tagged with an end-of-pass flag.
// Read side is fall-through: pop_row/pop_last show the head entry whenever count != 0.
module row_fifo
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] push_row,
    input  logic                                  push_last,
    input  logic                                  pop,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] pop_row,
    output logic                                  pop_last,
    output logic                                  full,
    output logic [cnt_w(FIFO_DEPTH)-1:0]          count
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_mem_q [FIFO_DEPTH];
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]                 last_mem_q, last_mem_d;
    logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  do_push, do_pop;

    assign full     = (cnt_q == FULL_CNT);
    assign count    = cnt_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && (cnt_q != '0);
    assign pop_row  = row_mem_q[rd_ptr_q];
    assign pop_last = last_mem_q[rd_ptr_q];

    always_comb begin
        row_mem_d  = row_mem_q;
        last_mem_d = last_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (do_push) begin
            row_mem_d[wr_ptr_q]  = push_row;
            last_mem_d[wr_ptr_q] = push_last;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and count define emptiness, so the storage itself needs no reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        row_mem_q  <= row_mem_d;
        last_mem_q <= last_mem_d;
    end

endmodule

// File: rtl/skew_feeder.sv
// Buffers row vectors and re-times each into a diagonal wavefront for the array edge,
// bracketing one matrix pass with start / busy / done.
//
//   state  | meaning
//   IDLE   | waiting for start; FIFO may be prefilled
//   STREAM | pop one row per cycle, bubble when FIFO empty
//   DRAIN  | MATRIX_SIZE cycles for the last row to leave the skew chains
//   DONE   | one-cycle done pulse, then back to IDLE
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_data,
    input  logic                                  in_last,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
    output logic [MATRIX_SIZE-1:0]                out_valid,
    output logic                                  busy,
    output logic                                  done
);

    localparam int CNT_W   = cnt_w(FIFO_DEPTH);
    localparam int DRAIN_W = drain_w(MATRIX_SIZE);

    state_e                                state_q, state_d;
    logic [DRAIN_W-1:0]                    drain_cnt_q, drain_cnt_d;
    logic                                  ready_q, ready_d;
    logic                                  pop;
    logic                                  fifo_full;
    logic                                  fifo_empty;
    logic [CNT_W-1:0]                      fifo_count;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] fifo_row;
    logic                                  fifo_last;

    // ready_q keeps in_ready low through reset and for the cycle it is released in.
    assign ready_d    = 1'b1;
    assign in_ready   = ready_q && !fifo_full;
    assign fifo_empty = (fifo_count == '0);

    row_fifo #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_row  (in_data),
        .push_last (in_last),
        .pop       (pop),
        .pop_row   (fifo_row),
        .pop_last  (fifo_last),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = STREAM;
            end
            STREAM: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_W'(MATRIX_SIZE);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(1)) state_d = DONE;
                else                            drain_cnt_d = drain_cnt_q - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            STREAM, DRAIN: busy = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    // Stage 0 of every lane is the pop register; lane i adds i further stages.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        logic [i:0]                v_q, v_d;
        logic [i:0][DATA_SIZE-1:0] d_q, d_d;

        always_comb begin
            v_d[0] = pop;
            d_d[0] = pop ? fifo_row[i] : '0;
            for (int s = 1; s <= i; s++) begin
                v_d[s] = v_q[s-1];
                d_d[s] = d_q[s-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= '0;
                d_q <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign out_valid[i] = v_q[i];
        assign out_data[i]  = v_q[i] ? d_q[i] : '0;
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder at MATRIX_SIZE=2, DATA_SIZE=32, FIFO_DEPTH=4.
module tb_skew_feeder;
    import systolic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    row_t       in_data;
    logic       in_last;
    row_t       out_data;
    logic [1:0] out_valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    skew_feeder #(
        .MATRIX_SIZE (2),
        .DATA_SIZE   (32),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected lane values of 0 mean the lane is idle (invalid, zero data).
    task automatic chk_cycle(input string tag, input int c, input logic [31:0] e0,
                             input logic [31:0] e1, input int dc);
        string t;
        t = $sformatf("%s c%0d", tag, c);
        chk({t, " v0"},   64'(out_valid[0]), 64'(e0 != 0));
        chk({t, " d0"},   64'(out_data[0]),  64'(e0));
        chk({t, " v1"},   64'(out_valid[1]), 64'(e1 != 0));
        chk({t, " d1"},   64'(out_data[1]),  64'(e1));
        chk({t, " busy"}, 64'(busy),         64'(c < dc));
        chk({t, " done"}, 64'(done),         64'(c == dc));
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drive_row(input logic [31:0] a, input logic [31:0] b, input logic l);
        in_valid   = 1'b1;
        in_data[0] = a;
        in_data[1] = b;
        in_last    = l;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        // reset state
        repeat (2) nxt();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data",  64'(out_data[0] | out_data[1]), 64'd0);
        chk("rst busy",      64'(busy), 64'd0);
        chk("rst done",      64'(done), 64'd0);
        chk("rst in_ready",  64'(in_ready), 64'd0);
        reset = 1'b0;
        nxt();
        chk("post-rst in_ready", 64'(in_ready), 64'd1);

        // prefill two rows then stream
        drive_row(1, 2, 1'b0);
        nxt();
        drive_row(3, 4, 1'b1);
        nxt();
        in_valid = 1'b0;
        start    = 1'b1;
        chk("t1 count", 64'(dut.fifo_count), 64'd2);
        nxt();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            nxt();
            chk_cycle("t1", c, (c == 1) ? 32'd1 : (c == 2) ? 32'd3 : 32'd0,
                      (c == 2) ? 32'd2 : (c == 3) ? 32'd4 : 32'd0, 4);
        end

        // fill until full; fifth row must be refused
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2 in_ready k%0d", k), 64'(in_ready), 64'(k < 4));
            drive_row(32'(20 + k), 32'(30 + k), k == 3);
            nxt();
            chk($sformatf("t2 count k%0d", k), 64'(dut.fifo_count), 64'((k < 4) ? k + 1 : 4));
        end
        in_valid = 1'b0;
        start    = 1'b1;
        nxt();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            chk_cycle("t2", c, (c <= 4) ? 32'(19 + c) : 32'd0,
                      (c >= 2 && c <= 5) ? 32'(28 + c) : 32'd0, 6);
        end
        chk("t2 count end", 64'(dut.fifo_count), 64'd0);

        // start on empty FIFO, row arrives late
        start = 1'b1;
        nxt();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            chk_cycle("t3", c, (c == 4) ? 32'd7 : 32'd0, (c == 5) ? 32'd8 : 32'd0, 6);
            if (c == 2) drive_row(7, 8, 1'b1);
            if (c == 3) in_valid = 1'b0;
        end

        // reset mid-DRAIN
        drive_row(40, 41, 1'b1);
        nxt();
        drive_row(50, 51, 1'b0);
        nxt();
        in_valid = 1'b0;
        start    = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        chk("t4 c1 d0", 64'(out_data[0]), 64'd40);
        nxt();
        chk("t4 c2 v1", 64'(out_valid[1]), 64'd1);
        chk("t4 c2 d1", 64'(out_data[1]), 64'd41);
        #1 reset = 1'b1;
        #1;
        chk("t4 async out_valid", 64'(out_valid), 64'd0);
        chk("t4 async out_data",  64'(out_data[0] | out_data[1]), 64'd0);
        chk("t4 async busy",      64'(busy), 64'd0);
        chk("t4 async in_ready",  64'(in_ready), 64'd0);
        chk("t4 async count",     64'(dut.fifo_count), 64'd0);
        chk("t4 async state",     64'(dut.state_q), 64'(IDLE));
        nxt();
        chk("t4 rst done", 64'(done), 64'd0);
        reset = 1'b0;
        nxt();
        chk("t4 rel in_ready", 64'(in_ready), 64'd1);
        chk("t4 rel done",     64'(done), 64'd0);
        chk("t4 rel busy",     64'(busy), 64'd0);
        chk("t4 rel count",    64'(dut.fifo_count), 64'd0);
        nxt();
        chk("t4 rel2 done",    64'(done), 64'd0);

        // start pulses mid-pass ignored; second row stays queued
        drive_row(9, 10, 1'b1);
        nxt();
        drive_row(11, 12, 1'b0);
        nxt();
        in_valid = 1'b0;
        start    = 1'b1;
        nxt();
        for (int c = 1; c <= 5; c++) begin
            nxt();
            if (c == 1) start = 1'b0;
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
            chk_cycle("t5", c, (c == 1) ? 32'd9 : 32'd0, (c == 2) ? 32'd10 : 32'd0, 3);
        end
        chk("t6 count queued", 64'(dut.fifo_count), 64'd1);
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        chk("t6 c1 d0", 64'(out_data[0]), 64'd11);
        chk("t6 c1 v1", 64'(out_valid[1]), 64'd0);
        nxt();
        chk("t6 c2 d1", 64'(out_data[1]), 64'd12);
        chk("t6 c2 v0", 64'(out_valid[0]), 64'd0);
        chk("t6 c2 busy", 64'(busy), 64'd1);
        chk("t6 count end", 64'(dut.fifo_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Downstream stage of the systolic-array data fetch path.
- Buffers row vectors from the fetch stage in a small FIFO.
- Re-times each row into a diagonal wavefront for the array edge: lane i of a row is delayed i cycles relative to lane 0.
- Brackets one matrix pass with a start command, a busy flag and a done pulse.

Parameters:
- MATRIX_SIZE, 2, number of lanes (array rows/cols); must be >= 1.
- DATA_SIZE, 32, bits per element.
- FIFO_DEPTH, 4, row-vector FIFO entries; must be a power of two and >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a pass; sampled only in IDLE.
- in_valid  in  1  in_data/in_last hold a row.
- in_ready  out  1  FIFO can accept a row.
- in_data  in  DATA_SIZE x MATRIX_SIZE  row vector; element i goes to lane i.
- in_last  in  1  marks the final row of the pass.
- out_data  out  DATA_SIZE x MATRIX_SIZE  skewed lane data to the array.
- out_valid  out  MATRIX_SIZE  per-lane valid.
- busy  out  1  high in STREAM and DRAIN.
- done  out  1  single-cycle pulse at pass end.

Behaviour:
- Reset: clk and reset as decided above.
  - Asserting reset, including mid-pass, empties the FIFO, clears all skew registers, and forces state to IDLE.
  - During reset: out_data = 0, out_valid = 0, busy = 0, done = 0, in_ready = 0.
  - in_ready rises in the first cycle after reset deasserts.
- FIFO:
  - Each entry holds a row plus its last flag.
  - Push when in_valid && in_ready; in_ready = !full.
  - Pushes are accepted in every state, including IDLE, so the FIFO can be prefilled.
  - A push and a pop in the same cycle are legal when not full; the count is unchanged.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count is one bit wider than the pointers.
- State machine: IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM on start. start in any other state is ignored.
  - STREAM:
    - Pops one row per cycle while the FIFO is non-empty.
    - When empty, inserts a bubble: no pop, lane-0 stage invalid, zeros.
    - Popping a row whose last flag is set moves the state to DRAIN on that edge.
  - DRAIN:
    - No pops; lasts exactly MATRIX_SIZE cycles, counted by a $clog2(MATRIX_SIZE)+1 bit counter.
    - Then -> DONE.
  - DONE: done = 1 for one cycle, then -> IDLE.
- Skew timing (pop at edge k):
  - Element i appears on out_data[i] with out_valid[i] = 1 in cycle k+i, where cycle k is the cycle following edge k.
  - Lane 0 therefore has 1-cycle latency from the pop.
  - done is asserted in cycle k+MATRIX_SIZE after the last row's pop; lane MATRIX_SIZE-1 has already delivered its final element.
- Output gating: out_data[i] = 0 whenever out_valid[i] = 0. Bubbles propagate down the skew chain as zero/invalid.
- Skew structure: lane i holds an i-deep register chain of {valid, data}. Lane 0 has no chain beyond the pop register.
- MATRIX_SIZE = 1: no skew; DRAIN lasts 1 cycle.
- Concurrent push while STREAM pops an empty FIFO: the pop waits until the next cycle. The row pushed in cycle n is poppable in cycle n+1 at the earliest.
- Rows pushed after the last row, or in DRAIN/DONE, remain in the FIFO for the next pass.

Decomposition:
- Shared package systolic_pkg:
  - state enum typedef (IDLE, STREAM, DRAIN, DONE).
  - row typedef: DATA_SIZE-bit element array of MATRIX_SIZE.
  - localparam helpers for pointer and count widths.
- One sub-module: row_fifo, a parameterised synchronous FIFO of row+last entries with full/empty/count.
- Skew chains and the FSM stay in skew_feeder.

Test Plan (MATRIX_SIZE=2, DATA_SIZE=32, FIFO_DEPTH=4):
- Prefill {1,2}, {3,4}(last) in IDLE, then start at edge 0 -> out_data[0] = 1 in cycle 1, 3 in cycle 2; out_data[1] = 2 in cycle 2, 4 in cycle 3; done = 1 only in cycle 4; busy in cycles 1-3.
- Push 5 rows with no pops -> in_ready = 0 after the 4th accepted push; 5th row is not accepted; FIFO contents unchanged.
- Start with an empty FIFO, push {7,8}(last) 3 cycles later -> out_valid = 0 with zero data during the bubbles; lane 0 shows 7 one cycle after the pop, lane 1 shows 8 one cycle later; done follows 2 cycles after the pop.
- Assert reset while lane 1 still holds a valid element in DRAIN -> outputs zero immediately (asynchronous); state IDLE, FIFO empty, no done pulse.
- Pulse start during STREAM and DRAIN -> no effect; a single done pulse occurs per pass.
- Rows {9,10}(last), {11,12} pushed before the pass -> first pass outputs only 9/10; {11,12} stays queued (count = 1) and streams on the next start.
